// File: rtl/vx_gbar_pkg.sv
// -----------------------------------------------------------------------------
// vx_gbar_pkg
// Shared types and configuration for the global barrier unit.
//   - GBAR_NUM_BARRIERS / GBAR_NUM_CORES : cluster configuration
//   - bar_id_w() / core_id_w()           : width helpers for ids and sizes
//   - gbar_req_t                         : arrival request {id, size_m1, core_id}
//   - gbar_slot_state_t                  : per-barrier registers {mask, size, open}
//   - gbar_phase_e                       : per-barrier phase (IDLE / COLLECTING)
// -----------------------------------------------------------------------------
package vx_gbar_pkg;

    localparam int GBAR_NUM_BARRIERS = 4;
    localparam int GBAR_NUM_CORES    = 4;

    // A single-entry space still needs one bit to carry a value.
    function automatic int bar_id_w(input int num_barriers);
        return (num_barriers > 1) ? $clog2(num_barriers) : 1;
    endfunction

    function automatic int core_id_w(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

    localparam int GBAR_BAR_ID_W  = bar_id_w(GBAR_NUM_BARRIERS);
    localparam int GBAR_CORE_ID_W = core_id_w(GBAR_NUM_CORES);

    typedef struct packed {
        logic [GBAR_BAR_ID_W-1:0]  id;
        logic [GBAR_CORE_ID_W-1:0] size_m1;
        logic [GBAR_CORE_ID_W-1:0] core_id;
    } gbar_req_t;

    typedef struct packed {
        logic [GBAR_NUM_CORES-1:0] mask;
        logic [GBAR_CORE_ID_W-1:0] size;
        logic                      open;
    } gbar_slot_state_t;

    typedef enum logic {
        SLOT_IDLE       = 1'b0,
        SLOT_COLLECTING = 1'b1
    } gbar_phase_e;

endpackage

// File: rtl/vx_gbar_slot.sv
// -----------------------------------------------------------------------------
// vx_gbar_slot
// One barrier id: arrival mask, recorded participant count and open flag.
// Detects duplicate arrivals and size mismatches and decides, combinationally
// for the current request, whether this arrival completes the epoch.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   hit       in   an accepted request targets this barrier this cycle
//   size_m1   in   request participant count minus one
//   core_id   in   arriving core
//   phase     out  IDLE / COLLECTING (registered)
//   complete  out  this accept closes the epoch (release on the next cycle)
//   dup       out  this accept is a repeat arrival and is dropped
//   size_err  out  this accept carries a size different from the stored one
// -----------------------------------------------------------------------------
module vx_gbar_slot
    import vx_gbar_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hit,
    input  logic [GBAR_CORE_ID_W-1:0] size_m1,
    input  logic [GBAR_CORE_ID_W-1:0] core_id,
    output gbar_phase_e               phase,
    output logic                      complete,
    output logic                      dup,
    output logic                      size_err
);

    // Popcount of a NUM_CORES mask fits in CORE_ID_W+1 bits.
    localparam int CNT_W = GBAR_CORE_ID_W + 1;

    gbar_slot_state_t          st_q;
    gbar_slot_state_t          st_d;
    logic [GBAR_NUM_CORES-1:0] core_oh;
    logic [GBAR_NUM_CORES-1:0] base_mask;
    logic [GBAR_NUM_CORES-1:0] new_mask;
    logic [GBAR_CORE_ID_W-1:0] eff_size;
    logic [CNT_W-1:0]          arrived;
    logic                      collecting;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign collecting = st_q.open;
    assign phase      = collecting ? SLOT_COLLECTING : SLOT_IDLE;

    always_comb begin
        core_oh          = '0;
        core_oh[core_id] = 1'b1;

        // An idle barrier starts from an empty mask and adopts the request
        // size; an open one keeps whatever size its first arrival recorded.
        base_mask = collecting ? st_q.mask : '0;
        eff_size  = collecting ? st_q.size : size_m1;

        dup      = hit && collecting && (|(st_q.mask & core_oh));
        size_err = hit && collecting && !dup && (size_m1 != st_q.size);

        new_mask = base_mask | core_oh;
        arrived  = '0;
        for (int i = 0; i < GBAR_NUM_CORES; i++) begin
            arrived = arrived + CNT_W'(new_mask[i]);
        end

        // Release fires at equality, so the count can never overshoot.
        complete = hit && !dup && (arrived == ({1'b0, eff_size} + CNT_W'(1)));

        st_d = st_q;
        if (hit && !dup) begin
            if (!collecting) begin
                st_d.size = size_m1;
            end
            if (complete) begin
                st_d.mask = '0;
                st_d.open = 1'b0;
            end else begin
                st_d.mask = new_mask;
                st_d.open = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_gbar_unit.sv
// -----------------------------------------------------------------------------
// vx_gbar_unit
// Global barrier controller shared by all cores of the cluster. Collects
// arrivals per barrier id and broadcasts a one-cycle release when the last
// participant arrives; the barrier then reopens for its next epoch.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is low during reset and high from the first edge after it; the
// unit never stalls. rsp_valid is a one-cycle pulse with no backpressure, and
// rsp_id holds the last released id between pulses.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   req_valid      in   arrival request valid
//   req_id         in   barrier id
//   req_size_m1    in   participant count minus one
//   req_core_id    in   arriving core
//   req_ready      out  request accept
//   rsp_valid      out  release pulse, one cycle after the completing accept
//   rsp_id         out  released barrier id
//   busy           out  some barrier has at least one pending arrival
//   err_dup        out  sticky: a core arrived twice within one epoch
//   err_size       out  sticky: an arrival's size disagreed with the epoch's
//   release_count  out  releases since reset, wrapping
// -----------------------------------------------------------------------------
module vx_gbar_unit
    import vx_gbar_pkg::*;
#(
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NUM_CORES    = GBAR_NUM_CORES,
    parameter int BAR_ID_W     = bar_id_w(NUM_BARRIERS),
    parameter int CORE_ID_W    = core_id_w(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [BAR_ID_W-1:0]  req_id,
    input  logic [CORE_ID_W-1:0] req_size_m1,
    input  logic [CORE_ID_W-1:0] req_core_id,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [BAR_ID_W-1:0]  rsp_id,
    output logic                 busy,
    output logic                 err_dup,
    output logic                 err_size,
    output logic [31:0]          release_count
);

    gbar_req_t                 req;
    logic                      accept;
    logic [NUM_BARRIERS-1:0]   hit;
    logic [NUM_BARRIERS-1:0]   slot_complete;
    logic [NUM_BARRIERS-1:0]   slot_dup;
    logic [NUM_BARRIERS-1:0]   slot_size_err;
    gbar_phase_e               slot_phase [NUM_BARRIERS];
    logic                      any_release;
    logic [BAR_ID_W-1:0]       release_id;
    logic                      busy_d;

    assign req    = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};
    assign accept = req_valid && req_ready;

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        assign hit[b] = accept && (req.id == BAR_ID_W'(b));

        vx_gbar_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .hit      (hit[b]),
            .size_m1  (req.size_m1),
            .core_id  (req.core_id),
            .phase    (slot_phase[b]),
            .complete (slot_complete[b]),
            .dup      (slot_dup[b]),
            .size_err (slot_size_err[b])
        );
    end

    // Only one request is accepted per cycle, so at most one slot completes.
    always_comb begin
        any_release = |slot_complete;
        release_id  = '0;
        busy_d      = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (slot_complete[b]) begin
                release_id = BAR_ID_W'(b);
            end
            if (slot_phase[b] == SLOT_COLLECTING) begin
                busy_d = 1'b1;
            end
        end
    end

    assign busy = busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            err_dup       <= 1'b0;
            err_size      <= 1'b0;
            release_count <= '0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= any_release;
            if (any_release) begin
                rsp_id        <= release_id;
                release_count <= release_count + 32'd1;
            end
            if (|slot_dup) begin
                err_dup <= 1'b1;
            end
            if (|slot_size_err) begin
                err_size <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_gbar_unit.sv
module tb_vx_gbar_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_id;
    logic [1:0]  req_size_m1;
    logic [1:0]  req_core_id;
    logic        req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        busy;
    logic        err_dup;
    logic        err_size;
    logic [31:0] release_count;

    int checks;
    int failures;

    vx_gbar_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_id        (req_id),
        .req_size_m1   (req_size_m1),
        .req_core_id   (req_core_id),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .busy          (busy),
        .err_dup       (err_dup),
        .err_size      (err_size),
        .release_count (release_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Presents one request on the falling edge, lets the next rising edge take
    // it, and returns 1 time unit after that edge so outputs can be sampled.
    task automatic send(input logic [1:0] id, input logic [1:0] sz, input logic [1:0] core);
        @(negedge clk);
        req_valid   = 1'b1;
        req_id      = id;
        req_size_m1 = sz;
        req_core_id = core;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_ready_low", req_ready, 1'b0);
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk32("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_err_dup", err_dup, 1'b0);
        chk1("reset_err_size", err_size, 1'b0);
        chk32("reset_count", release_count, 32'd0);
        reset = 1'b1;
        #1;
        chk1("ready_before_edge", req_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("ready_after_edge", req_ready, 1'b1);
        chk1("post_reset_rsp", rsp_valid, 1'b0);
        chk1("post_reset_busy", busy, 1'b0);
    endtask

    task automatic test_full_barrier;
        send(2'd1, 2'd3, 2'd0);
        chk1("full_c0_rsp", rsp_valid, 1'b0);
        chk1("full_c0_busy", busy, 1'b1);
        send(2'd1, 2'd3, 2'd1);
        chk1("full_c1_rsp", rsp_valid, 1'b0);
        send(2'd1, 2'd3, 2'd2);
        chk1("full_c2_rsp", rsp_valid, 1'b0);
        chk1("full_c2_busy", busy, 1'b1);
        send(2'd1, 2'd3, 2'd3);
        chk1("full_release", rsp_valid, 1'b1);
        chk32("full_rsp_id", 32'(rsp_id), 32'd1);
        chk1("full_busy_fall", busy, 1'b0);
        chk32("full_count", release_count, 32'd1);
        @(posedge clk);
        #1;
        chk1("full_pulse_one_cycle", rsp_valid, 1'b0);
        chk32("full_rsp_id_held", 32'(rsp_id), 32'd1);
    endtask

    task automatic test_single;
        send(2'd2, 2'd0, 2'd3);
        chk1("single_release", rsp_valid, 1'b1);
        chk32("single_rsp_id", 32'(rsp_id), 32'd2);
        chk1("single_busy", busy, 1'b0);
        chk32("single_count", release_count, 32'd2);
    endtask

    task automatic test_dup;
        send(2'd0, 2'd2, 2'd0);
        chk1("dup_err_clear", err_dup, 1'b0);
        send(2'd0, 2'd2, 2'd0);
        chk1("dup_err_set", err_dup, 1'b1);
        chk1("dup_no_release", rsp_valid, 1'b0);
        chk1("dup_busy", busy, 1'b1);
        send(2'd0, 2'd2, 2'd1);
        chk1("dup_c1_no_release", rsp_valid, 1'b0);
        send(2'd0, 2'd2, 2'd2);
        chk1("dup_release", rsp_valid, 1'b1);
        chk32("dup_rsp_id", 32'(rsp_id), 32'd0);
        chk32("dup_count", release_count, 32'd3);
        chk1("dup_err_size_clear", err_size, 1'b0);
    endtask

    task automatic test_size_interleave;
        send(2'd0, 2'd1, 2'd0);
        send(2'd3, 2'd1, 2'd1);
        chk1("mix_b3_no_release", rsp_valid, 1'b0);
        send(2'd0, 2'd2, 2'd2);
        chk1("mix_err_size", err_size, 1'b1);
        chk1("mix_release", rsp_valid, 1'b1);
        chk32("mix_rsp_id", 32'(rsp_id), 32'd0);
        chk32("mix_count", release_count, 32'd4);
        chk1("mix_busy_b3", busy, 1'b1);
        chk1("mix_err_dup_sticky", err_dup, 1'b1);
        send(2'd3, 2'd1, 2'd0);
        chk1("mix_b3_release", rsp_valid, 1'b1);
        chk32("mix_b3_rsp_id", 32'(rsp_id), 32'd3);
        chk1("mix_b3_busy_fall", busy, 1'b0);
    endtask

    task automatic test_back_to_back;
        send(2'd1, 2'd1, 2'd0);
        send(2'd1, 2'd1, 2'd1);
        chk1("b2b_release", rsp_valid, 1'b1);
        chk32("b2b_rsp_id", 32'(rsp_id), 32'd1);
        chk32("b2b_count", release_count, 32'd6);
        // Arrival presented during the release pulse opens a new epoch.
        send(2'd1, 2'd1, 2'd0);
        chk1("b2b_new_epoch_rsp", rsp_valid, 1'b0);
        chk1("b2b_new_epoch_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("async_busy", busy, 1'b0);
        chk1("async_ready", req_ready, 1'b0);
        chk32("async_count", release_count, 32'd0);
        chk1("async_err_dup", err_dup, 1'b0);
        chk1("async_err_size", err_size, 1'b0);
        chk32("async_rsp_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("async_no_rsp", rsp_valid, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk1("async_ready_back", req_ready, 1'b1);
        chk1("async_still_no_rsp", rsp_valid, 1'b0);
        // Mask was cleared: core 1 alone must not complete a 2-core epoch.
        send(2'd1, 2'd1, 2'd1);
        chk1("after_reset_no_release", rsp_valid, 1'b0);
        chk1("after_reset_busy", busy, 1'b1);
        send(2'd1, 2'd1, 2'd0);
        chk1("after_reset_release", rsp_valid, 1'b1);
        chk32("after_reset_count", release_count, 32'd1);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;

        test_reset();
        test_full_barrier();
        test_single();
        test_dup();
        test_size_interleave();
        test_back_to_back();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_gbar_unit.md
Name: vx_gbar_unit

Overview:
- Global barrier controller that sits behind the per-socket barrier arbiters and serves all cores in the cluster.
- Collects barrier arrivals, each tagged with barrier id, expected participant count and core id.
- Tracks one arrival mask per barrier id.
- When the last participant arrives, it broadcasts a one-cycle release carrying the barrier id and reopens that barrier for its next epoch.

Parameters:
- NUM_BARRIERS, 4, number of independent barrier ids (power of two, ≥2).
- NUM_CORES, 4, total participating cores (power of two, ≥2).
- BAR_ID_W, $clog2(NUM_BARRIERS), barrier id width.
- CORE_ID_W, $clog2(NUM_CORES), core id / size width.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  arrival request valid.
- req_id  input  BAR_ID_W  barrier id.
- req_size_m1  input  CORE_ID_W  participant count minus one.
- req_core_id  input  CORE_ID_W  arriving core.
- req_ready  output  1  accept; a request transfers on req_valid & req_ready.
- rsp_valid  output  1  one-cycle release pulse; no backpressure.
- rsp_id  output  BAR_ID_W  released barrier id; held until the next release.
- busy  output  1  any barrier has ≥1 arrival pending.
- err_dup  output  1  sticky: a core arrived twice in one epoch.
- err_size  output  1  sticky: size mismatched the epoch's recorded size.
- release_count  output  32  total releases since reset, wraps.

Behaviour:
- Reset (reset=0, asynchronous): all masks=0, all size regs=0, all epoch_open=0, rsp_valid=0, rsp_id=0, err_dup=0, err_size=0, release_count=0, req_ready=0. Reset mid-epoch discards all pending arrivals silently, with no release.
- req_ready=1 from the first clk edge after reset deasserts and stays 1. The block never stalls; every accepted arrival is processed in one cycle.
- Per barrier b, state is mask[b] (NUM_CORES bits), size[b] (CORE_ID_W bits) and open[b] (1 bit). States per barrier are IDLE (open=0) and COLLECTING (open=1).
- Accept in IDLE: size[b]<=req_size_m1; mask[b]<=onehot(core); open[b]<=1. If req_size_m1==0, release immediately (see release rule) and stay IDLE.
- Accept in COLLECTING: if mask[b][core] is already set, set err_dup and drop the request, with no other state change. Else if req_size_m1!=size[b], set err_size and still record the arrival using the stored size[b]. Else set mask[b][core].
- Release rule: compute new_mask = mask|onehot(core). If popcount(new_mask)==size[b]+1 at the accept edge, then:
  - mask[b]<=0 and open[b]<=0;
  - on the next cycle, rsp_valid=1 and rsp_id=b for exactly one cycle;
  - release_count+=1, wrapping from 0xFFFFFFFF to 0.
- Release latency: one cycle from the accepting edge to rsp_valid high.
- Back-to-back: an arrival for barrier b in the cycle rsp_valid pulses for b starts a new epoch (IDLE path). At most one arrival is accepted per cycle, so at most one release occurs per cycle.
- popcount exceeding size+1 cannot happen because the release fires at equality. A size shrink only raises err_size; the stored size governs.
- busy = OR over b of open[b], registered state only.
- Error flags are sticky until reset.

Decomposition:
- Shared package vx_gbar_pkg holds:
  - the gbar_req_t struct {id, size_m1, core_id};
  - the BAR_ID_W and CORE_ID_W localparam functions;
  - the per-barrier state struct {mask, size, open}.
- One sub-module, vx_gbar_slot: a single barrier's mask/size/open registers, duplicate and mismatch detection, and the completion compare. It is instantiated NUM_BARRIERS times.
- The top level handles id decode, the release pulse register, the flags and the counter.

Test Plan:
- Reset release: reset low for 3 cycles then high → req_ready=0 while reset is asserted, 1 on the first edge after release; all other outputs 0.
- Full barrier, NUM_CORES=4: id=1, size_m1=3, cores 0,1,2,3 on consecutive cycles → rsp_valid=1, rsp_id=1 exactly one cycle after core 3 is accepted. busy falls with release. release_count=1.
- Single participant: id=2, size_m1=0, core 3 → release one cycle later with rsp_id=2, mask stays 0, busy never asserts.
- Duplicate arrival: id=0, size_m1=2, cores 0,0,1,2 → err_dup=1 after the second core 0. Release fires after core 2; the duplicate is not counted.
- Size mismatch plus interleave: id=0 size_m1=1 core0; id=3 size_m1=1 core1; id=0 size_m1=2 core2 → err_size=1, barrier 0 releases after the third request (stored size 1). Barrier 3 stays open; busy=1.
- Epoch reuse and async reset: complete id=1, then id=1 core0 in the rsp_valid cycle, then assert reset mid-epoch → new epoch opens. After reset all masks=0 and no rsp_valid appears.
